// File: rtl/seg_rx_pkg.sv
// Shared package for the 7-segment display link.
// Contents:
//   u6 / u28 / u32 : width typedefs shared with the display block
//   segt[0:16]     : segment encodings; 0..15 are hex digits, 16 is blank
//   hex_t          : result of a reverse lookup (valid flag plus nibble)
//   seg2hex        : segment byte -> hex nibble reverse lookup
package seg_rx_pkg;

  typedef logic [5:0]  u6;
  typedef logic [27:0] u28;
  typedef logic [31:0] u32;

  localparam logic [7:0] segt [0:16] = '{
    8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
    8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71,
    8'hff
  };

  localparam u6 BcntMax  = 6'd31;
  localparam u6 WordBits = 6'd16;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

  // Only the 16 digit codes are searched; the blank code is not a digit.
  function automatic hex_t seg2hex(input logic [7:0] seg);
    hex_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == segt[i]) begin
        res.vld = 1'b1;
        res.nib = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_rx_if.sv
// Link and result bundle of the segment receiver.
// Link lines : sclk, ds, stclk (driven by the link master)
// Results    : val, frame_vld, dig_mask, dig_err, sel_err, frame_err, err_cnt
// master : drives the link, observes results (bench / display side)
// slave  : the receiver
interface seg_rx_if
  import seg_rx_pkg::*;
#(
  parameter int unsigned ERRW = 16
);
  logic            sclk;
  logic            ds;
  logic            stclk;
  u32              val;
  logic            frame_vld;
  logic [7:0]      dig_mask;
  logic            dig_err;
  logic            sel_err;
  logic            frame_err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output sclk, ds, stclk,
    input  val, frame_vld, dig_mask, dig_err, sel_err, frame_err, err_cnt
  );

  modport slave (
    input  sclk, ds, stclk,
    output val, frame_vld, dig_mask, dig_err, sel_err, frame_err, err_cnt
  );
endinterface

// File: rtl/seg_rx_sync_edge.sv
// SYNC-stage synchronizer with rising-edge detect for one async line.
// Ports:
//   clk, rst : system clock, async active-high reset
//   i_d      : asynchronous input line
//   o_lvl    : synchronized level
//   o_rise   : one-cycle pulse on a synchronized 0->1 transition
module seg_rx_sync_edge #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise
);
  logic [SYNC-1:0] r_sync;
  logic            r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], i_d};
      r_prev <= r_sync[SYNC-1];
    end
  end

  assign o_lvl  = r_sync[SYNC-1];
  assign o_rise = r_sync[SYNC-1] & ~r_prev;
endmodule

// File: rtl/seg_rx.sv
// Serial receiver for the 7-segment display link.
// Reassembles 16-bit latched words {sel, seg}, maps each to one hex nibble of
// val and publishes a frame once all 8 digit positions have been refreshed.
// Ports:
//   clk, rst : system clock, async active-high reset
//   bus      : seg_rx_if slave (link lines in, value / status / errors out)
module seg_rx
  import seg_rx_pkg::*;
#(
  parameter int unsigned SYNC = 2,
  parameter int unsigned ERRW = 16
) (
  input logic     clk,
  input logic     rst,
  seg_rx_if.slave bus
);
  logic w_sh_p, w_lt_p, w_ds;
  logic w_sclk_lvl, w_stclk_lvl, w_ds_rise;

  seg_rx_sync_edge #(.SYNC(SYNC)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.sclk),
    .o_lvl  (w_sclk_lvl),
    .o_rise (w_sh_p)
  );

  seg_rx_sync_edge #(.SYNC(SYNC)) u_sync_ds (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.ds),
    .o_lvl  (w_ds),
    .o_rise (w_ds_rise)
  );

  seg_rx_sync_edge #(.SYNC(SYNC)) u_sync_stclk (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.stclk),
    .o_lvl  (w_stclk_lvl),
    .o_rise (w_lt_p)
  );

  logic w_unused;
  assign w_unused = w_sclk_lvl ^ w_stclk_lvl ^ w_ds_rise;

  logic [15:0]     r_sr;
  u6               r_bcnt;
  u32              r_val;
  logic [7:0]      r_dig_mask;
  logic            r_frame_vld;
  logic            r_dig_err;
  logic            r_sel_err;
  logic            r_frame_err;
  logic [ERRW-1:0] r_err_cnt;

  // Word decode uses r_sr as held before any coincident shift.
  logic [7:0] w_sel, w_seg;
  hex_t       w_hex;
  logic [2:0] w_k;
  logic       w_frame_err, w_sel_err, w_dig_err, w_wr;
  logic [7:0] w_mask_base, w_mask_d;
  logic       w_err_any;

  assign {w_sel, w_seg} = r_sr;
  assign w_hex          = seg2hex(w_seg);

  // Select bit p maps to nibble 7-p.
  always_comb begin
    w_k = '0;
    for (int p = 0; p < 8; p++) begin
      if (w_sel[p]) w_k = 3'(7 - p);
    end
  end

  // Priority: bit count, then select, then segment code; one pulse per latch.
  assign w_frame_err = w_lt_p && (r_bcnt != WordBits);
  assign w_sel_err   = w_lt_p && !w_frame_err && !$onehot(w_sel);
  assign w_dig_err   = w_lt_p && !w_frame_err && !w_sel_err && !w_hex.vld;
  assign w_wr        = w_lt_p && !w_frame_err && !w_sel_err && w_hex.vld;

  // Mask clears the cycle after a completed frame; no carry-over.
  assign w_mask_base = r_frame_vld ? 8'h00 : r_dig_mask;
  assign w_mask_d    = w_wr ? (w_mask_base | (8'h01 << w_k)) : w_mask_base;

  assign w_err_any = r_frame_err | r_sel_err | r_dig_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_bcnt      <= '0;
      r_val       <= '0;
      r_dig_mask  <= '0;
      r_frame_vld <= 1'b0;
      r_dig_err   <= 1'b0;
      r_sel_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_sh_p) r_sr <= {w_ds, r_sr[15:1]};

      if (w_lt_p) begin
        r_bcnt <= w_sh_p ? 6'd1 : 6'd0;
      end else if (w_sh_p && (r_bcnt != BcntMax)) begin
        r_bcnt <= r_bcnt + 6'd1;
      end

      r_frame_err <= w_frame_err;
      r_sel_err   <= w_sel_err;
      r_dig_err   <= w_dig_err;

      if (w_wr) r_val[{w_k, 2'b00} +: 4] <= w_hex.nib;
      r_dig_mask  <= w_mask_d;
      r_frame_vld <= w_wr && (w_mask_d == 8'hff);

      if (w_err_any && (r_err_cnt != {ERRW{1'b1}})) r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

  assign bus.val       = r_val;
  assign bus.frame_vld = r_frame_vld;
  assign bus.dig_mask  = r_dig_mask;
  assign bus.dig_err   = r_dig_err;
  assign bus.sel_err   = r_sel_err;
  assign bus.frame_err = r_frame_err;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_seg_rx.sv
// Self-checking bench for seg_rx: directed link words, a per-latch outcome
// model with cycle-level compare, and literal checks of known results.
module tb_seg_rx;
  localparam int unsigned SYNC = 2;
  localparam int unsigned ERRW = 16;
  localparam int          Lat  = SYNC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_fv = 0;

  always #5 clk = ~clk;

  seg_rx_if #(.ERRW(ERRW)) bus ();

  seg_rx #(.SYNC(SYNC), .ERRW(ERRW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] seg_tab [16] = '{
    8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
    8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Model state
  logic [31:0]     m_val = '0;
  logic [7:0]      m_mask = '0;
  logic [ERRW-1:0] m_err = '0;
  logic            m_fv = 1'b0, m_de = 1'b0, m_se = 1'b0, m_fe = 1'b0;
  int              p_due = -1, p_kind = 0, p_k = 0;
  logic [3:0]      p_nib = '0;
  int              clr_due = -1, err_due = -1;
  bit              rxq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of a latch: bits received since the previous latch decide it.
  task automatic model_latch();
    logic [15:0] w;
    logic [7:0]  sel, seg;
    int          hit;
    w = '0; hit = -1;
    p_kind = 0; p_k = 0; p_nib = '0;
    if (rxq.size() != 16) begin
      p_kind = 1;
    end else begin
      for (int i = 0; i < 16; i++) w[i] = rxq[i];
      sel = w[15:8];
      seg = w[7:0];
      if ($countones(sel) != 1) begin
        p_kind = 2;
      end else begin
        for (int d = 0; d < 16; d++) if (seg_tab[d] == seg) hit = d;
        if (hit < 0) p_kind = 3;
        else begin
          p_nib = 4'(hit);
          for (int b = 0; b < 8; b++) if (sel[b]) p_k = 7 - b;
        end
      end
    end
    rxq.delete();
    p_due = cyc + Lat;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle-by-cycle compare against the model
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      m_val = '0; m_mask = '0; m_err = '0;
      m_fv = 0; m_de = 0; m_se = 0; m_fe = 0;
      p_due = -1; clr_due = -1; err_due = -1;
      chk("rst_val", bus.val, 32'h0);
      chk("rst_mask", {24'h0, bus.dig_mask}, 32'h0);
      chk("rst_pulses", {28'h0, bus.frame_vld, bus.dig_err, bus.sel_err, bus.frame_err}, 32'h0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    end else begin
      m_fv = 0; m_de = 0; m_se = 0; m_fe = 0;
      if (cyc == clr_due) m_mask = '0;
      if (cyc == err_due && m_err != '1) m_err = m_err + 1'b1;
      if (cyc == p_due) begin
        case (p_kind)
          1: begin m_fe = 1; err_due = cyc + 1; end
          2: begin m_se = 1; err_due = cyc + 1; end
          3: begin m_de = 1; err_due = cyc + 1; end
          default: begin
            m_val[4*p_k +: 4] = p_nib;
            m_mask[p_k] = 1'b1;
            if (m_mask == 8'hff) begin
              m_fv = 1;
              clr_due = cyc + 1;
            end
          end
        endcase
      end
      n_fv += int'(bus.frame_vld);
      chk("val", bus.val, m_val);
      chk("dig_mask", {24'h0, bus.dig_mask}, {24'h0, m_mask});
      chk("pulses", {28'h0, bus.frame_vld, bus.dig_err, bus.sel_err, bus.frame_err},
          {28'h0, m_fv, m_de, m_se, m_fe});
      chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    bus.ds = b;
    tick(4);
    bus.sclk = 1'b1;
    rxq.push_back(b);
    tick(4);
    bus.sclk = 1'b0;
  endtask

  task automatic latch();
    model_latch();
    bus.stclk = 1'b1;
    tick(4);
    bus.stclk = 1'b0;
    tick(4);
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) shift_bit(w[i]);
    latch();
    tick(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxq.delete();
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  int fv0;

  initial begin
    bus.sclk = 1'b0; bus.ds = 1'b0; bus.stclk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Full frame 0..7
    fv0 = n_fv;
    for (int i = 0; i < 8; i++) send_word({8'h80 >> i, seg_tab[i]}, 16);
    chk("frame1_val", bus.val, 32'h76543210);
    chk("frame1_model_val", m_val, 32'h76543210);
    chk("frame1_mask", {24'h0, bus.dig_mask}, 32'h0);
    chk("frame1_count", 32'(n_fv - fv0), 32'd1);

    // Bad segment code
    send_word({8'h01, 8'hff}, 16);
    chk("dig_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("dig_err_val", bus.val, 32'h76543210);

    // Select not one-hot
    send_word({8'h81, 8'h03}, 16);
    send_word({8'h00, 8'h03}, 16);
    chk("sel_err_cnt", 32'(bus.err_cnt), 32'd3);

    // Short word, then a proper one
    send_word({8'h80, 8'h9f}, 15);
    chk("frame_err_cnt", 32'(bus.err_cnt), 32'd4);
    chk("frame_err_val", bus.val, 32'h76543210);
    send_word({8'h80, 8'h9f}, 16);
    chk("after_ferr_val", bus.val, 32'h76543211);
    chk("after_ferr_mask", {24'h0, bus.dig_mask}, 32'h01);

    // Four more digits, partial word, then reset
    for (int i = 1; i < 5; i++) send_word({8'h80 >> i, seg_tab[i+9]}, 16);
    chk("pre_rst_mask", {24'h0, bus.dig_mask}, 32'h1f);
    for (int i = 0; i < 7; i++) shift_bit(1'b1);
    do_reset();
    chk("post_rst_val", bus.val, 32'h0);
    chk("post_rst_err", 32'(bus.err_cnt), 32'h0);

    // Frame 8..f after reset
    fv0 = n_fv;
    for (int i = 0; i < 8; i++) begin
      send_word({8'h80 >> i, seg_tab[8+i]}, 16);
      if (i == 6) chk("frame2_pending", 32'(n_fv - fv0), 32'd0);
    end
    chk("frame2_val", bus.val, 32'hfedcba98);
    chk("frame2_count", 32'(n_fv - fv0), 32'd1);

    // Coincident shift and latch: word A latched, bit belongs to word B
    for (int i = 0; i < 16; i++) shift_bit(logic'((16'h2025 >> i) & 1));
    bus.ds = 1'b1;  // bit 0 of {8'h01, 8'h0d}
    tick(4);
    model_latch();
    rxq.push_back(1'b1);
    bus.sclk = 1'b1;
    bus.stclk = 1'b1;
    tick(4);
    bus.sclk = 1'b0;
    bus.stclk = 1'b0;
    for (int i = 1; i < 16; i++) shift_bit(logic'((16'h010d >> i) & 1));
    latch();
    tick(4);
    chk("coinc_val", bus.val, 32'h3edcb298);
    chk("coinc_mask", {24'h0, bus.dig_mask}, 32'h84);
    chk("coinc_err", 32'(bus.err_cnt), 32'h0);

    // Rewrite a digit before the frame completes
    send_word({8'h20, 8'h99}, 16);
    chk("rewrite_val", bus.val, 32'h3edcb498);
    chk("rewrite_mask", {24'h0, bus.dig_mask}, 32'h84);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
